// File: rtl/encode_8b10b_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : encode_8b10b_pkg
//  Purpose  : Shared constants, legal control-byte list and encoder I/O types
//             for the multi-byte 8b/10b stream encoder.
//  Revision : 1.0  initial release
// ============================================================================
package encode_8b10b_pkg;

   localparam logic [7:0] K28_5       = 8'hBC;
   localparam int         SYM_W       = 10;
   localparam int         NUM_LEGAL_K = 12;

   // K28.0-K28.7, K23.7, K27.7, K29.7, K30.7
   localparam logic [7:0] LEGAL_K [NUM_LEGAL_K] = '{
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
      8'hF7, 8'hFB, 8'hFD, 8'hFE
   };

   typedef struct packed {
      logic       rd_in;
      logic [7:0] data;
      logic       k;
   } enc_in_t;

   typedef struct packed {
      logic [SYM_W-1:0] sym;
      logic             rd_out;
      logic             kerr;
   } enc_out_t;

   function automatic logic is_legal_k(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_LEGAL_K; i++) begin
         if (b == LEGAL_K[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage
`default_nettype wire

// File: rtl/enc8b10b_byte.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : enc8b10b_byte
//  Purpose  : Combinational single-byte 8b/10b encoder with running
//             disparity in/out and an illegal-control-byte flag.
//             Output bit order {j,h,g,f,i,e,d,c,b,a}, a at LSB.
//  Revision : 1.0  initial release
// ============================================================================
module enc8b10b_byte
   import encode_8b10b_pkg::*;
(
   input  enc_in_t  enc_in,
   output enc_out_t enc_out
);

   // RD- column of the 5b/6b code, literature order abcdei (a at MSB)
   function automatic logic [5:0] data_6b(input logic [4:0] x);
      logic [5:0] c;
      case (x)
         5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;
         5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
         5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
         5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
         5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;
         5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
         5'd12: c = 6'b001101;  5'd13: c = 6'b101100;
         5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
         5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
         5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
         5'd20: c = 6'b001011;  5'd21: c = 6'b101010;
         5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
         5'd24: c = 6'b110011;  5'd25: c = 6'b100110;
         5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
         5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
         5'd30: c = 6'b011110;
         default: c = 6'b101011;
      endcase
      return c;
   endfunction

   // RD- column of the 3b/4b code, literature order fghj (f at MSB)
   function automatic logic [3:0] data_4b(input logic [2:0] y);
      logic [3:0] c;
      case (y)
         3'd0: c = 4'b1011;  3'd1: c = 4'b1001;
         3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
         3'd4: c = 4'b1101;  3'd5: c = 4'b1010;
         3'd6: c = 4'b0110;
         default: c = 4'b1110;
      endcase
      return c;
   endfunction

   logic [4:0]       x5;
   logic [2:0]       y3;
   logic             is_k28;
   logic             unbal6;
   logic             unbal4;
   logic             rd6;
   logic             alt7;
   logic             k28_bal;
   logic [5:0]       c6;
   logic [3:0]       c4;
   logic [SYM_W-1:0] lit;

   // 6b sub-block, intermediate disparity, 4b sub-block, then a-first bit order
   always_comb begin
      x5     = enc_in.data[4:0];
      y3     = enc_in.data[7:5];
      is_k28 = enc_in.k && (x5 == 5'd28);
      c6     = is_k28 ? 6'b001111 : data_6b(x5);
      unbal6 = ($countones(c6) != 3);
      // D7 is balanced but still has distinct RD-/RD+ forms
      if (enc_in.rd_in && (unbal6 || (x5 == 5'd7))) c6 = ~c6;
      rd6    = enc_in.rd_in ^ unbal6;
      // Alternate x.7 avoids a run of five equal bits across the sub-block boundary
      alt7   = (y3 == 3'd7) &&
               (enc_in.k ||
                (!rd6 && ((x5 == 5'd17) || (x5 == 5'd18) || (x5 == 5'd20))) ||
                ( rd6 && ((x5 == 5'd11) || (x5 == 5'd13) || (x5 == 5'd14))));
      c4     = alt7 ? 4'b0111 : data_4b(y3);
      unbal4 = ($countones(c4) != 2);
      // K28's balanced 4b codes invert when the 6b left disparity negative,
      // which keeps the comma unique
      k28_bal = is_k28 && !unbal4 && (y3 != 3'd3);
      if ((rd6 && (unbal4 || (y3 == 3'd3))) || (!rd6 && k28_bal)) c4 = ~c4;
      lit = {c6, c4};
      enc_out = '0;
      for (int i = 0; i < SYM_W; i++) enc_out.sym[i] = lit[SYM_W-1-i];
      enc_out.rd_out = rd6 ^ unbal4;
      enc_out.kerr   = enc_in.k && !is_legal_k(enc_in.data);
   end

endmodule
`default_nettype wire

// File: rtl/encode_8b10b_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : encode_8b10b_stream
//  Purpose  : Registered NUM_BYTES-wide 8b/10b encoder with valid/ready
//             handshake and a running disparity chained across bytes and
//             cycles. Optional idle fill with K28.5 words when the macro
//             ENCODE_8B10B_STREAM_IDLE_FILL_EN is defined (adds out_idle).
//  Revision : 1.0  initial release
// ============================================================================
module encode_8b10b_stream
   import encode_8b10b_pkg::*;
#(
   parameter int NUM_BYTES = 2,
   parameter bit RD_INIT   = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [8*NUM_BYTES-1:0]     in_data,
   input  logic [NUM_BYTES-1:0]       in_k,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [SYM_W*NUM_BYTES-1:0] out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_BYTES-1:0]       out_kerr,
`ifdef ENCODE_8B10B_STREAM_IDLE_FILL_EN
   output logic                       out_idle,
`endif
   output logic                       rd_out
);

   logic                       accept;
   logic                       fill;
   logic                       load;
   logic                       rd_q;
   logic [8*NUM_BYTES-1:0]     enc_data;
   logic [NUM_BYTES-1:0]       enc_k;
   logic [NUM_BYTES:0]         rd_chain;
   logic [SYM_W*NUM_BYTES-1:0] sym_word;
   logic [NUM_BYTES-1:0]       kerr_word;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
`ifdef ENCODE_8B10B_STREAM_IDLE_FILL_EN
   // Fill only when the register would otherwise go empty; real data wins
   assign fill     = in_ready && !in_valid;
`else
   assign fill     = 1'b0;
`endif
   assign load     = accept || fill;
   assign enc_data = fill ? {NUM_BYTES{K28_5}} : in_data;
   assign enc_k    = fill ? {NUM_BYTES{1'b1}} : in_k;
   assign rd_chain[0] = rd_q;
   assign rd_out      = rd_q;

   generate
      for (genvar n = 0; n < NUM_BYTES; n++) begin : g_byte
         enc_in_t  ein;
         enc_out_t eout;
         assign ein = '{rd_in: rd_chain[n], data: enc_data[8*n +: 8], k: enc_k[n]};
         enc8b10b_byte u_enc (
            .enc_in  (ein),
            .enc_out (eout)
         );
         assign sym_word[SYM_W*n +: SYM_W] = eout.sym;
         assign rd_chain[n+1]              = eout.rd_out;
         assign kerr_word[n]               = eout.kerr;
      end
   endgenerate

   // Output stage: load on accept/fill, empty on take, hold under backpressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_kerr  <= '0;
         out_valid <= 1'b0;
         rd_q      <= RD_INIT;
`ifdef ENCODE_8B10B_STREAM_IDLE_FILL_EN
         out_idle  <= 1'b0;
`endif
      end else if (load) begin
         out_data  <= sym_word;
         out_kerr  <= fill ? '0 : kerr_word;
         out_valid <= 1'b1;
         rd_q      <= rd_chain[NUM_BYTES];
`ifdef ENCODE_8B10B_STREAM_IDLE_FILL_EN
         out_idle  <= fill;
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_encode_8b10b_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_encode_8b10b_stream
//  Purpose  : Self-checking bench for encode_8b10b_stream (NUM_BYTES = 2)
//             against a table-driven 8b/10b reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_encode_8b10b_stream;

   localparam int NB       = 2;
   localparam bit RDI      = 1'b0;
   localparam int NUM_RAND = 10000;

   logic            clk = 1'b0;
   logic            rst;
   logic [8*NB-1:0] in_data;
   logic [NB-1:0]   in_k;
   logic            in_valid;
   logic            in_ready;
   logic [10*NB-1:0] out_data;
   logic            out_valid;
   logic            out_ready;
   logic [NB-1:0]   out_kerr;
   logic            rd_out;
`ifdef ENCODE_8B10B_STREAM_IDLE_FILL_EN
   logic            out_idle;
`endif

   always #5 clk = ~clk;

   encode_8b10b_stream #(.NUM_BYTES(NB), .RD_INIT(RDI)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_k      (in_k),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_kerr  (out_kerr),
`ifdef ENCODE_8B10B_STREAM_IDLE_FILL_EN
      .out_idle  (out_idle),
`endif
      .rd_out    (rd_out)
   );

   // ---------------- reference model tables (literature bit order) --------
   logic [5:0] t6n [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
      6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
      6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
      6'b011110, 6'b101011};
   logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                           4'b1101, 4'b1010, 4'b0110, 4'b1110};
   logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                           4'b0010, 4'b1010, 4'b0110, 4'b0001};
   // K28.y 4b code indexed by the disparity entering the symbol
   logic [3:0] k4n [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                           4'b0010, 4'b1010, 4'b0110, 4'b1000};
   logic [3:0] k4p [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                           4'b1101, 4'b0101, 4'b1001, 4'b0111};
   logic [7:0] legal_k [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

   function automatic void enc_ref(input bit rd_i, input logic [7:0] b, input bit k,
                                   output logic [9:0] sym, output bit rd_o, output bit kerr);
      int x, y;
      logic [5:0] s6;
      logic [3:0] s4;
      logic [9:0] l;
      bit rd6;
      x = int'(b[4:0]);
      y = int'(b[7:5]);
      if (k && x == 28) begin
         s6 = rd_i ? 6'b110000 : 6'b001111;
         s4 = rd_i ? k4p[y] : k4n[y];
      end else begin
         s6 = t6n[x];
         if (rd_i && ($countones(s6) != 3 || x == 7)) s6 = ~s6;
         rd6 = rd_i ^ ($countones(s6) != 3);
         if (y == 7 && (k || (!rd6 && x inside {17, 18, 20}) || (rd6 && x inside {11, 13, 14})))
            s4 = rd6 ? 4'b1000 : 4'b0111;
         else
            s4 = rd6 ? t4p[y] : t4n[y];
      end
      rd_o = rd_i ^ ($countones(s6) != 3) ^ ($countones(s4) != 2);
      l    = {s6, s4};
      sym  = {<<{l}};
      kerr = k && !(b inside {8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                              8'hF7, 8'hFB, 8'hFD, 8'hFE});
   endfunction

   function automatic void word_ref(input logic [8*NB-1:0] d, input logic [NB-1:0] k,
                                    inout bit rd, output logic [10*NB-1:0] s,
                                    output logic [NB-1:0] ke);
      logic [9:0] sy;
      bit r, e;
      for (int n = 0; n < NB; n++) begin
         enc_ref(rd, d[8*n +: 8], k[n], sy, r, e);
         s[10*n +: 10] = sy;
         ke[n] = e;
         rd = r;
      end
   endfunction

   // ---------------- checking ---------------------------------------------
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   bit               rd_m;
   logic [10*NB-1:0] m_data;
   logic [NB-1:0]    m_kerr;

   task automatic send_word(input logic [15:0] d, input logic [1:0] k);
      @(posedge clk); #1;
      in_data = d; in_k = k; in_valid = 1'b1; out_ready = 1'b1;
      word_ref(d, k, rd_m, m_data, m_kerr);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // ---------------- scoreboard for the random phase ----------------------
   typedef struct packed {
      logic [10*NB-1:0] d;
      logic [NB-1:0]    ke;
      logic             rd;
   } sb_t;
   sb_t exp_q[$];
   bit  sb_on = 1'b0;
   bit  rd_sb;

   // Take before push: an accepted word only reaches the output after the edge
   always @(negedge clk) begin
      sb_t e;
      logic [10*NB-1:0] s;
      logic [NB-1:0] ke;
      if (sb_on) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb extra word", 32'(exp_q.size()), 1);
            else begin
               e = exp_q.pop_front();
               chk("sb data", out_data, e.d);
               chk("sb kerr", out_kerr, e.ke);
               chk("sb rd", rd_out, e.rd);
            end
         end
         if (in_valid && in_ready) begin
            word_ref(in_data, in_k, rd_sb, s, ke);
            exp_q.push_back('{d: s, ke: ke, rd: rd_sb});
         end
      end
   end

   task automatic rand_word();
      for (int n = 0; n < NB; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 7) begin
            in_k[n] = 1'b0; in_data[8*n +: 8] = 8'($urandom);
         end else if (r < 9) begin
            in_k[n] = 1'b1; in_data[8*n +: 8] = legal_k[$urandom_range(0, 11)];
         end else begin
            in_k[n] = 1'b1; in_data[8*n +: 8] = 8'($urandom);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10*NB-1:0] ad, bd;
      logic [NB-1:0]    ak, bk;
      bit               rd_a;
      logic             acc;
      int               sent;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_k = '0;
      rd_m = RDI;
      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_kerr", out_kerr, 0);
      chk("reset rd_out", rd_out, RDI);
      chk("reset in_ready", in_ready, 1);
      rst = 1'b0;

`ifdef ENCODE_8B10B_STREAM_IDLE_FILL_EN
      out_ready = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         word_ref(16'hBCBC, 2'b11, rd_m, m_data, m_kerr);
         chk("idle valid", out_valid, 1);
         chk("idle flag", out_idle, 1);
         chk("idle data", out_data, m_data);
         chk("idle kerr", out_kerr, 0);
         chk("idle rd", rd_out, rd_m);
      end
`else
      // K28.5 pair from RD-: 0x17C then 0x283, disparity back to negative
      send_word(16'hBCBC, 2'b11);
      chk("k285 pair data", out_data, {10'h283, 10'h17C});
      chk("k285 pair rd", rd_out, 0);
      chk("k285 pair kerr", out_kerr, 0);
      chk("k285 pair valid", out_valid, 1);
      // D21.5 then K28.5 from RD-, then again from RD+
      send_word(16'hBCB5, 2'b10);
      chk("d215 rdneg data", out_data, {10'h17C, 10'h155});
      chk("d215 rdneg rd", rd_out, 1);
      send_word(16'hBCB5, 2'b10);
      chk("d215 rdpos data", out_data, {10'h283, 10'h155});
      chk("d215 rdpos rd", rd_out, 0);
      // D0.0 pair from RD-
      send_word(16'h0000, 2'b00);
      chk("d00 pair data", out_data, {10'h0B9, 10'h0B9});
      chk("d00 pair rd", rd_out, 0);
      // K28.7 (legal, alternate 4b) and K on 0x00 (illegal)
      send_word(16'h00FC, 2'b11);
      chk("k287 illegal data", out_data, {10'h0B9, 10'h07C});
      chk("k287 illegal kerr", out_kerr, 2'b10);
      chk("k287 illegal rd", rd_out, 0);
      // Every legal control byte
      for (int i = 0; i < 12; i += 2) begin
         send_word({legal_k[i+1], legal_k[i]}, 2'b11);
         chk("legal k data", out_data, m_data);
         chk("legal k kerr", out_kerr, 0);
         chk("legal k rd", rd_out, rd_m);
      end

      // Backpressure: word A held for 5 cycles while B waits
      @(posedge clk); #1;
      in_data = 16'h3CB5; in_k = 2'b10; in_valid = 1'b1; out_ready = 1'b0;
      word_ref(16'h3CB5, 2'b10, rd_m, ad, ak);
      rd_a = rd_m;
      @(posedge clk); #1;
      in_data = 16'hF74A; in_k = 2'b10;
      word_ref(16'hF74A, 2'b10, rd_m, bd, bk);
      repeat (5) begin
         chk("bp in_ready", in_ready, 0);
         chk("bp data held", out_data, ad);
         chk("bp rd held", rd_out, rd_a);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp next data", out_data, bd);
      chk("bp next valid", out_valid, 1);
      chk("bp next rd", rd_out, rd_m);
      @(posedge clk); #1;
      chk("drain valid", out_valid, 0);
      chk("drain data hold", out_data, bd);

      // Asynchronous reset while a word is stalled with positive disparity
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1;
      if (rd_m) begin in_data = 16'hB5B5; in_k = 2'b00; end
      else      begin in_data = 16'hB5BC; in_k = 2'b01; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pre-reset valid", out_valid, 1);
      chk("pre-reset rd", rd_out, 1);
      #2 rst = 1'b1;
      #1;
      chk("async rst valid", out_valid, 0);
      chk("async rst rd", rd_out, RDI);
      chk("async rst data", out_data, 0);
      @(negedge clk);
      rst = 1'b0;

      // Random valid/ready traffic against the scoreboard
      rd_sb = RDI;
      @(posedge clk); #1;
      out_ready = 1'b1;
      sb_on = 1'b1;
      sent = 0;
      while (sent < NUM_RAND) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
         out_ready = ($urandom_range(0, 3) != 0);
         if (acc || !in_valid) begin
            in_valid = (sent < NUM_RAND) && ($urandom_range(0, 3) != 0);
            rand_word();
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("sb drain", 32'(exp_q.size()), 0);
      sb_on = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
